// File: rtl/sram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port SRAM.
package sram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } sram_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int num_bytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/sram_dp_be_if.sv
// Request/response bundle between a client and the dual-port SRAM.
interface sram_dp_be_if
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH);

    logic                  chip_enable_n;
    logic                  write_enable_n;
    logic [NUM_BYTES-1:0]  write_byte_en_n;
    logic [ADDR_WIDTH-1:0] wr_address;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read_enable_n;
    logic [ADDR_WIDTH-1:0] rd_address;
    logic                  clear_req_n;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  init_busy;

    modport master (
        output chip_enable_n, write_enable_n, write_byte_en_n, wr_address, data_in,
        output read_enable_n, rd_address, clear_req_n,
        input  data_out, data_valid, init_busy
    );

    modport slave (
        input  chip_enable_n, write_enable_n, write_byte_en_n, wr_address, data_in,
        input  read_enable_n, rd_address, clear_req_n,
        output data_out, data_valid, init_busy
    );

endinterface

// File: rtl/sram_rd_pipe.sv
// Delay line for read results; each stage carries {valid, data} and data is zero when not valid.
module sram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    generate
        if (STAGES == 0) begin : g_passthru
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_pipe
            for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
                logic                  valid_reg;
                logic [DATA_WIDTH-1:0] data_reg;
                logic                  v_in;
                logic [DATA_WIDTH-1:0] d_in;

                if (gi == 0) begin : g_first
                    assign v_in = in_valid;
                    assign d_in = in_data;
                end else begin : g_chain
                    assign v_in = g_stage[gi-1].valid_reg;
                    assign d_in = g_stage[gi-1].data_reg;
                end

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        valid_reg <= 1'b0;
                        data_reg  <= '0;
                    end else begin
                        valid_reg <= v_in;
                        data_reg  <= v_in ? d_in : '0;
                    end
                end
            end

            assign out_valid = g_stage[STAGES-1].valid_reg;
            assign out_data  = g_stage[STAGES-1].data_reg;
        end
    endgenerate

endmodule

// File: rtl/sram_dp_be.sv
// Simple dual-port SRAM with byte-lane writes, pipelined reads, RDW policy and a sequential clear engine.
module sram_dp_be
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int MEM_SIZE       = 1 << ADDR_WIDTH,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = RDW_OLD,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    sram_dp_be_if.slave bus
);

    localparam int                    NUM_BYTES   = num_bytes(DATA_WIDTH, BYTE_WIDTH);
    localparam logic [ADDR_WIDTH:0]   MEM_SIZE_W  = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST    = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam sram_state_e           RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    sram_state_e           state_reg, state_next;
    logic [ADDR_WIDTH-1:0] clr_cnt_reg, clr_cnt_next;
    logic                  clear_active;
    logic                  ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= RESET_STATE;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    // Counter only advances inside CLEAR, so every clear starts from address 0.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = '0;
        case (state_reg)
            ST_CLEAR: begin
                if (clr_cnt_reg == CLR_LAST) begin
                    state_next = ST_READY;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
            ST_READY: begin
                if (!bus.clear_req_n) begin
                    state_next = ST_CLEAR;
                end
            end
            default: state_next = RESET_STATE;
        endcase
    end

    always_comb begin
        clear_active = (state_reg == ST_CLEAR);
        ready        = (state_reg == ST_READY);
    end

    assign bus.init_busy = clear_active;

    logic wr_in_range, rd_in_range, wr_accept, rd_accept, byp_hit;

    assign wr_in_range = ({1'b0, bus.wr_address} < MEM_SIZE_W);
    assign rd_in_range = ({1'b0, bus.rd_address} < MEM_SIZE_W);
    assign wr_accept   = ready && !bus.chip_enable_n && !bus.write_enable_n && wr_in_range;
    assign rd_accept   = ready && !bus.chip_enable_n && !bus.read_enable_n;
    assign byp_hit     = (RDW_MODE == RDW_NEW) && wr_accept && rd_accept
                         && (bus.wr_address == bus.rd_address);

    // Single write port shared by the clear engine and client writes.
    logic [NUM_BYTES-1:0]  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        mem_we    = '0;
        mem_waddr = bus.wr_address;
        mem_wdata = bus.data_in;
        if (clear_active) begin
            mem_we    = '1;
            mem_waddr = clr_cnt_reg;
            mem_wdata = '0;
        end else if (wr_accept) begin
            mem_we = ~bus.write_byte_en_n;
        end
    end

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
    logic [DATA_WIDTH-1:0] rd_word_reg;

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (mem_we[k]) begin
                mem[mem_waddr][k*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        if (rd_accept && rd_in_range) begin
            rd_word_reg <= mem[bus.rd_address];
        end
    end

    // Bypass lanes are captured alongside the read so the array keeps a plain registered read.
    logic                  rd_valid_reg;
    logic                  rd_in_range_reg;
    logic [NUM_BYTES-1:0]  byp_mask_reg;
    logic [DATA_WIDTH-1:0] byp_data_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_reg    <= 1'b0;
            rd_in_range_reg <= 1'b0;
            byp_mask_reg    <= '0;
            byp_data_reg    <= '0;
        end else begin
            rd_valid_reg    <= rd_accept;
            rd_in_range_reg <= rd_in_range;
            byp_mask_reg    <= byp_hit ? mem_we : '0;
            byp_data_reg    <= bus.data_in;
        end
    end

    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] stage1_data;

    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            assign merged_word[gi*BYTE_WIDTH +: BYTE_WIDTH] = byp_mask_reg[gi]
                ? byp_data_reg[gi*BYTE_WIDTH +: BYTE_WIDTH]
                : rd_word_reg[gi*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    assign stage1_data = (rd_valid_reg && rd_in_range_reg) ? merged_word : '0;

    logic                  pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data;

    sram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (READ_LATENCY - 1)
    ) u_rd_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (rd_valid_reg),
        .in_data   (stage1_data),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    assign bus.data_valid = pipe_valid;
    assign bus.data_out   = pipe_data;

endmodule
